// File: rtl/shift_counter_ctrl.sv
// Parametrised shift-register phase counter, ring or Johnson (twisted-ring) mode.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset; q returns to 0...01
//   en       - advance enable (shift one position per cycle)
//   mode     - 0 = ring, 1 = Johnson
//   dir      - 0 = forward (toward MSB), 1 = reverse
//   load     - synchronous parallel load of load_val (wins over en)
//   load_val - value written verbatim on load, legal or not
//   q        - registered counter state
//   idx      - decoded phase index of q (0 when q is illegal)
//   illegal  - q is not a legal state for the current mode
//   wrap     - one-cycle pulse after a shift crosses the period boundary
module shift_counter_ctrl #(
    parameter int WIDTH = 4,
    localparam int IW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             illegal,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ResetVal = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic             wrap_q;
    logic [WIDTH-1:0] shifted;
    logic             boundary;
    int               ones;
    int               trans;
    int               pos;
    int               idx_val;
    int               last;

    // Population count, adjacent-bit transitions and set-bit position feed both
    // the legality check and the phase decode.
    always_comb begin
        ones  = 0;
        trans = 0;
        pos   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {31'b0, q_q[i]};
            if (q_q[i]) begin
                pos = i;
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            trans = trans + {31'b0, q_q[i] ^ q_q[i+1]};
        end
    end

    always_comb begin
        illegal = mode ? (trans > 1) : (ones != 1);
        if (illegal) begin
            idx_val = 0;
        end else if (!mode) begin
            idx_val = pos;
        end else if (q_q[0]) begin
            idx_val = ones - 1;
        end else begin
            idx_val = 2 * WIDTH - 1 - ones;
        end
        idx  = IW'(idx_val);
        last = mode ? (2 * WIDTH - 1) : (WIDTH - 1);
    end

    always_comb begin
        unique case ({mode, dir})
            2'b00:   shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            2'b01:   shifted = {q_q[0], q_q[WIDTH-1:1]};
            2'b10:   shifted = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            default: shifted = {~q_q[0], q_q[WIDTH-1:1]};
        endcase
        // A legal shift moves idx by one, so the boundary is crossed exactly
        // when leaving the last phase forward or phase 0 in reverse.
        boundary = dir ? (idx_val == 0) : (idx_val == last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= ResetVal;
            wrap_q <= 1'b0;
        end else if (load) begin
            q_q    <= load_val;
            wrap_q <= 1'b0;
        end else if (en) begin
            if (illegal) begin
                q_q    <= ResetVal;
                wrap_q <= 1'b0;
            end else begin
                q_q    <= shifted;
                wrap_q <= boundary;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Bench for shift_counter_ctrl (WIDTH=4): directed vector table, hand-written
// corner sequences, then randomized stimulus against a phase-based model.
module tb_shift_counter_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, mode, dir, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic [2:0]   idx;
    logic         illegal, wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         r, e, m, d, l;
        logic [W-1:0] lv;
        logic [W-1:0] eq;
        logic [2:0]   ei;
        logic         eil, ew;
    } vec_t;

    vec_t tbl[$];

    // Model state: counter contents and pending wrap.
    logic [W-1:0] mq;
    logic         mw;

    shift_counter_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .idx      (idx),
        .illegal  (illegal),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Pattern of phase k: ring is a single one at k; Johnson fills ones from
    // the LSB for the first W phases, then drains them from the LSB.
    function automatic logic [W-1:0] gen(input logic m, input int k);
        int c;
        if (!m) return W'(1 << k);
        if (k < W) return W'((1 << (k + 1)) - 1);
        c = 2 * W - 1 - k;
        return W'(((1 << c) - 1) << (W - c));
    endfunction

    // Phase of v under mode m, or -1 if v is not a legal state.
    function automatic int find(input logic m, input logic [W-1:0] v);
        int p;
        p = m ? 2 * W : W;
        for (int k = 0; k < p; k++) begin
            if (gen(m, k) == v) return k;
        end
        return -1;
    endfunction

    task automatic drive(input logic r, e, m, d, l, input logic [W-1:0] lv);
        int p, k;
        @(negedge clk);
        reset = r; en = e; mode = m; dir = d; load = l; load_val = lv;
        // Advance the model from the same inputs the DUT sees at the next edge.
        p = m ? 2 * W : W;
        k = find(m, mq);
        if (r) begin
            mq = W'(1); mw = 1'b0;
        end else if (l) begin
            mq = lv; mw = 1'b0;
        end else if (e) begin
            if (k < 0) begin
                mq = W'(1); mw = 1'b0;
            end else begin
                mw = d ? (k == 0) : (k == p - 1);
                mq = gen(m, d ? (k + p - 1) % p : (k + 1) % p);
            end
        end else begin
            mw = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [W-1:0] eq, input logic [2:0] ei,
                       input logic eil, input logic ew);
        total++;
        if (q !== eq || idx !== ei || illegal !== eil || wrap !== ew) begin
            bad++;
            $display("FAIL %s: got q=%b idx=%0d illegal=%b wrap=%b, want q=%b idx=%0d illegal=%b wrap=%b",
                     name, q, idx, illegal, wrap, eq, ei, eil, ew);
        end
    endtask

    task automatic cmp_model(input string name);
        int k;
        k = find(mode, mq);
        cmp(name, mq, (k < 0) ? 3'd0 : 3'(k), k < 0, mw);
    endtask

    task automatic add(input logic r, e, m, d, l, input logic [W-1:0] lv,
                       input logic [W-1:0] eq, input int ei, input logic eil, ew);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.d = d; v.l = l; v.lv = lv;
        v.eq = eq; v.ei = 3'(ei); v.eil = eil; v.ew = ew;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        mq = W'(1); mw = 1'b0;

        // Johnson forward full period
        add(1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0011, 1, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0111, 2, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1111, 3, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1110, 4, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1100, 5, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 6, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 7, 0, 0);
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
        add(0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        // Ring forward, then reverse across the boundary
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
        add(0, 1, 0, 1, 0, 4'b0000, 4'b1000, 3, 0, 1);
        add(0, 1, 0, 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
        // Johnson reverse, then mode switch makes 1111 illegal
        add(1, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add(0, 1, 1, 1, 0, 4'b0000, 4'b0000, 7, 0, 1);
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1000, 6, 0, 0);
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1100, 5, 0, 0);
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1110, 4, 0, 0);
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1111, 3, 0, 0);
        add(0, 0, 0, 1, 0, 4'b0000, 4'b1111, 0, 1, 0);
        add(0, 1, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].d, tbl[i].l, tbl[i].lv);
            cmp($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ei, tbl[i].eil, tbl[i].ew);
        end

        // Illegal load in Johnson mode, hold, then self-correct without wrap
        drive(1, 0, 1, 0, 0, 4'b0000);
        drive(0, 0, 1, 0, 1, 4'b0110);
        cmp("load_illegal", 4'b0110, 3'd0, 1'b1, 1'b0);
        drive(0, 0, 1, 0, 0, 4'b0000);
        cmp("hold_illegal", 4'b0110, 3'd0, 1'b1, 1'b0);
        drive(0, 1, 1, 0, 0, 4'b0000);
        cmp("correct", 4'b0001, 3'd0, 1'b0, 1'b0);

        // Load beats enable; the following shift wraps
        drive(0, 1, 0, 0, 1, 4'b1000);
        cmp("load_over_en", 4'b1000, 3'd3, 1'b0, 1'b0);
        drive(0, 1, 0, 0, 0, 4'b0000);
        cmp("wrap_after_load", 4'b0001, 3'd0, 1'b0, 1'b1);

        // Reset beats load and enable mid-Johnson run
        drive(1, 0, 1, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 4'b0000);
        cmp("johnson_1100", 4'b1100, 3'd5, 1'b0, 1'b0);
        drive(1, 1, 1, 0, 1, 4'b1111);
        cmp("reset_priority", 4'b0001, 3'd0, 1'b0, 1'b0);

        // Reset on the edge that would have set wrap suppresses it
        drive(0, 0, 0, 0, 1, 4'b1000);
        drive(1, 1, 0, 0, 0, 4'b0000);
        cmp("reset_clears_wrap", 4'b0001, 3'd0, 1'b0, 1'b0);

        // Randomized run against the phase model
        mq = W'(1); mw = 1'b0;
        drive(1, 0, 0, 0, 0, 4'b0000);
        cmp_model("rand_reset");
        for (int i = 0; i < 600; i++) begin
            logic r, e, m, d, l;
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 15) == 0) ? ~mode : mode;
            d = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            drive(r, e, m, d, l, 4'($urandom));
            cmp_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_counter_ctrl.md
Name: shift_counter_ctrl

Overview:
- Parametrised shift-register counter: the next generation of the team's fixed 3-bit twisted-ring counter.
- Generalised to WIDTH bits, with runtime selection of ring or Johnson (twisted-ring) mode.
- Adds bidirectional shifting, clock enable, synchronous parallel load, illegal-state detection with self-correction, a decoded phase index and a wrap pulse.
- Used as a phase/sequence generator for timing and scan logic.

Parameters:
- WIDTH, 4, register width in bits; legal range ≥2.
- IW, $clog2(2*WIDTH), width of idx (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- en  input  1  advance enable.
- mode  input  1  0 = ring, 1 = Johnson.
- dir  input  1  0 = forward (toward MSB), 1 = reverse.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  counter state (registered).
- idx  output  IW  decoded phase index of q (combinational from q).
- illegal  output  1  q is not a legal state for current mode (combinational).
- wrap  output  1  one-cycle period-boundary pulse (registered).

Behaviour:
- Clock, reset and priority:
  - One clock; reset is synchronous and active-high; all state updates on rising clk.
  - Priority per edge: reset > load > en > hold.
- Reset:
  - q = {0…0,1} (bit0 set) in both modes; wrap = 0.
  - Therefore idx = 0 and illegal = 0 after reset.
- Load:
  - q <= load_val verbatim, even if illegal (test hook).
  - wrap <= 0.
- Enable (en=1, load=0):
  - If illegal=1: q <= {0…0,1} (self-correct), wrap <= 0.
  - Else shift per mode and dir:
    - Ring, fwd: q <= {q[W-2:0], q[W-1]}.
    - Ring, rev: q <= {q[0], q[W-1:1]}.
    - Johnson, fwd: q <= {q[W-2:0], ~q[W-1]}.
    - Johnson, rev: q <= {~q[0], q[W-1:1]}.
- Hold (en=0, load=0): q holds; wrap <= 0.
- Period P: WIDTH in ring mode, 2*WIDTH in Johnson mode.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: count of i in 0..W-2 with q[i]≠q[i+1] is ≤1 (2W states, all-zero and all-one included).
- idx decode:
  - Ring: position of the set bit.
  - Johnson, q[0]=1: popcount(q)−1.
  - Johnson, q[0]=0: 2W−1−popcount(q).
  - Illegal q: idx = 0.
  - Forward shifting increments idx mod P; reverse decrements.
- wrap:
  - Asserted for exactly one cycle, the cycle after a legal shift crosses the boundary (fwd idx P−1→0; rev idx 0→P−1).
  - Never asserted by load, correction, hold or reset.
- Mode change:
  - Takes effect on the next shift; no state is rewritten.
  - A state illegal under the new mode is flagged immediately and corrected on the next enabled cycle.
  - Reset pattern 0…01 is legal in both modes.
- dir change: takes effect on the same edge it is sampled.
- Reset mid-operation: any q returns to 0…01 on the next edge; pending wrap is cleared.
- WIDTH=2: ring P=2 (01,10); Johnson P=4 (01,11,10,00).

Test Plan:
1. WIDTH=4, reset, mode=1, dir=0, en=1 for 8 cycles → q = 0001,0011,0111,1111,1110,1100,1000,0000,0001; idx = 0..7,0; wrap=1 only in the cycle after 0000→0001.
2. mode=0, dir=0, en=1 → q = 0001,0010,0100,1000,0001, idx = 0,1,2,3,0, wrap once. Then dir=1 from 0001 → 1000 (idx 3), wrap=1 next cycle.
3. mode=1, load=1 with load_val=0110 → q=0110, illegal=1, idx=0. en=0 holds 0110. en=1 → q=0001, illegal=0, wrap=0.
4. load=1 and en=1 together with load_val=1000, mode=0 → q=1000 (load wins), wrap=0. Next en cycle → 0001 with wrap pulse.
5. Johnson run to q=1100, assert reset with en=1 and load=1 → q=0001, idx=0, wrap=0 next cycle.
6. mode=1, dir=1 from reset → q = 0000 (idx 7, wrap=1 following cycle), 1000, 1100, 1110, 1111 (idx 3). Switch mode=0 at 1111 → illegal=1, next en → 0001.
